// File: rtl/fifo_wr_arbiter_if.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter_if
//
// Purpose: bundles the producer handshake, the FIFO write port and the
// arbiter status outputs of fifo_wr_arbiter into one interface.
//
// Signals:
//   req_valid      per-requester word valid            (producer -> arbiter)
//   req_data       packed words, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last       per-requester last-of-packet flag   (producer -> arbiter)
//   req_ready      per-requester accept                (arbiter -> producer)
//   fifo_full      FIFO full flag                      (FIFO -> arbiter)
//   fifo_half_full FIFO half-full flag                 (FIFO -> arbiter)
//   fifo_wr_en     FIFO write enable                   (arbiter -> FIFO)
//   fifo_wr_data   FIFO write data                     (arbiter -> FIFO)
//   grant_id       current or last granted requester
//   busy           burst in progress
//   burst_done     one-cycle pulse after a burst ends
//
// Modports:
//   slave  - the arbiter side
//   master - the environment side (producers + FIFO)
// -----------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_last;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          fifo_full;
   logic                          fifo_half_full;
   logic                          fifo_wr_en;
   logic [DATA_WIDTH-1:0]         fifo_wr_data;
   logic [ID_W-1:0]               grant_id;
   logic                          busy;
   logic                          burst_done;

   modport slave (
      input  req_valid,
      input  req_data,
      input  req_last,
      input  fifo_full,
      input  fifo_half_full,
      output req_ready,
      output fifo_wr_en,
      output fifo_wr_data,
      output grant_id,
      output busy,
      output burst_done
   );

   modport master (
      output req_valid,
      output req_data,
      output req_last,
      output fifo_full,
      output fifo_half_full,
      input  req_ready,
      input  fifo_wr_en,
      input  fifo_wr_data,
      input  grant_id,
      input  busy,
      input  burst_done
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Purpose: write-side arbiter for the 256-deep async FIFO, entirely in the
// wr_clk domain. Shares the single FIFO write port among NUM_REQ producers
// with round-robin, burst-granular grants. A burst ends on the producer's
// last word, after MAX_BURST beats, or after STALL_LIMIT consecutive cycles
// in which the granted producer has nothing to send while the FIFO has room.
//
// Ports:
//   wr_clk    in   write-domain clock (only clock)
//   wr_rst_n  in   asynchronous active-low reset
//   bus       slave modport of fifo_wr_arbiter_if (handshake, FIFO port,
//             grant_id / busy / burst_done status)
//
// Build option:
//   WR_ARB_HALF_FULL_THROTTLE_EN - when defined, a new grant additionally
//   requires fifo_half_full=0; a burst already in progress is unaffected.
//   When undefined, fifo_half_full is ignored.
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int DATA_WIDTH  = 32,
   parameter int MAX_BURST   = 16,
   parameter int STALL_LIMIT = 8
) (
   input  logic             wr_clk,
   input  logic             wr_rst_n,
   fifo_wr_arbiter_if.slave bus
);

   localparam int ID_W    = $clog2(NUM_REQ);
   localparam int BEAT_W  = $clog2(MAX_BURST + 1);
   localparam int STALL_W = $clog2(STALL_LIMIT + 1);

   localparam logic [ID_W-1:0]    ID_MAX     = ID_W'(NUM_REQ - 1);
   localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(MAX_BURST - 1);
   localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_LIMIT - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t             state_q;
   logic [ID_W-1:0]    grant_id_q;
   logic [ID_W-1:0]    rr_ptr_q;
   logic [BEAT_W-1:0]  beat_cnt_q;
   logic [STALL_W-1:0] stall_cnt_q;
   logic               busy_q;
   logic               burst_done_q;

   // Unpacked view of the producer words so the write mux is a plain index.
   logic [DATA_WIDTH-1:0] words [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_words
      assign words[gi] = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
   end

   // ---------------------------------------------------------------------------
   // Granted-requester view (valid only while in BURST)
   // ---------------------------------------------------------------------------
   logic               in_burst;
   logic               g_valid;
   logic               g_last;
   logic               accept;
   logic               stall;
   logic               burst_end;
   logic [NUM_REQ-1:0] ready_vec;

   assign in_burst = (state_q == BURST);
   assign g_valid  = bus.req_valid[grant_id_q];
   assign g_last   = bus.req_last[grant_id_q];

   // A full FIFO neither accepts nor stalls: the burst simply holds.
   assign accept = in_burst && g_valid && !bus.fifo_full;
   assign stall  = in_burst && !g_valid && !bus.fifo_full;

   assign burst_end = (accept && (g_last || (beat_cnt_q == BEAT_LAST))) ||
                      (stall && (stall_cnt_q == STALL_LAST));

   always_comb begin
      ready_vec = '0;
      if (in_burst) begin
         ready_vec[grant_id_q] = !bus.fifo_full;
      end
   end

   // ---------------------------------------------------------------------------
   // Round-robin winner search starting at rr_ptr, wrapping at NUM_REQ
   // (works for non-power-of-2 NUM_REQ).
   // ---------------------------------------------------------------------------
   logic            win_found;
   logic [ID_W-1:0] win_id;
   logic            grant_ok;
   logic [ID_W-1:0] rr_next;
   int              idx;

   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      idx       = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (!win_found && bus.req_valid[idx]) begin
            win_found = 1'b1;
            win_id    = ID_W'(idx);
         end
      end
   end

`ifdef WR_ARB_HALF_FULL_THROTTLE_EN
   assign grant_ok = win_found && !bus.fifo_full && !bus.fifo_half_full;
`else
   assign grant_ok = win_found && !bus.fifo_full;

   logic unused_half_full;
   assign unused_half_full = bus.fifo_half_full;
`endif

   assign rr_next = (grant_id_q == ID_MAX) ? '0 : grant_id_q + 1'b1;

   // ---------------------------------------------------------------------------
   // Control FSM. A burst end always returns to IDLE, so at least one IDLE
   // cycle separates consecutive bursts.
   // ---------------------------------------------------------------------------
   always_ff @(posedge wr_clk or negedge wr_rst_n) begin
      if (!wr_rst_n) begin
         state_q      <= IDLE;
         grant_id_q   <= '0;
         rr_ptr_q     <= '0;
         beat_cnt_q   <= '0;
         stall_cnt_q  <= '0;
         busy_q       <= 1'b0;
         burst_done_q <= 1'b0;
      end else begin
         burst_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (grant_ok) begin
                  state_q     <= BURST;
                  grant_id_q  <= win_id;
                  beat_cnt_q  <= '0;
                  stall_cnt_q <= '0;
                  busy_q      <= 1'b1;
               end
            end
            BURST: begin
               if (burst_end) begin
                  state_q      <= IDLE;
                  rr_ptr_q     <= rr_next;
                  busy_q       <= 1'b0;
                  burst_done_q <= 1'b1;
               end else if (accept) begin
                  beat_cnt_q  <= beat_cnt_q + 1'b1;
                  stall_cnt_q <= '0;
               end else if (stall) begin
                  stall_cnt_q <= stall_cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Handshake and write port are combinational so a beat moves in the same
   // cycle it is offered; status outputs come straight from registers.
   assign bus.req_ready    = ready_vec;
   assign bus.fifo_wr_en   = accept;
   assign bus.fifo_wr_data = words[grant_id_q];
   assign bus.grant_id     = grant_id_q;
   assign bus.busy         = busy_q;
   assign bus.burst_done   = burst_done_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Directed bench for fifo_wr_arbiter with default parameters
// (NUM_REQ=4, DATA_WIDTH=32, MAX_BURST=16, STALL_LIMIT=8). Honours the
// WR_ARB_HALF_FULL_THROTTLE_EN build option in the half-full sequence.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

   localparam int NREQ = 4;
   localparam int DW   = 32;

   logic clk;
   logic rst_n;

   int errors = 0;
   int checks = 0;

   fifo_wr_arbiter_if #(.NUM_REQ(NREQ), .DATA_WIDTH(DW)) bus ();

   fifo_wr_arbiter #(
      .NUM_REQ    (NREQ),
      .DATA_WIDTH (DW),
      .MAX_BURST  (16),
      .STALL_LIMIT(8)
   ) dut (
      .wr_clk   (clk),
      .wr_rst_n (rst_n),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [3:0] valid;
      logic [3:0] last;
      logic       full;
      logic [3:0] exp_ready;
      logic       exp_wr;
      logic [1:0] exp_gid;
      logic       exp_busy;
      logic       exp_done;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [DW-1:0] word_of(input int req, input int k);
      return 32'hC000_0000 + 32'(req << 16) + 32'(k);
   endfunction

   task automatic set_data(input int k);
      for (int i = 0; i < NREQ; i++) begin
         bus.req_data[i*DW +: DW] = word_of(i, k);
      end
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n              = 1'b0;
      bus.req_valid      = '0;
      bus.req_last       = '0;
      bus.fifo_full      = 1'b0;
      bus.fifo_half_full = 1'b0;
      set_data(0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic void add(input logic [3:0] v, input logic [3:0] l, input logic f,
                               input logic [3:0] rdy, input logic wr, input logic [1:0] gid,
                               input logic bsy, input logic dn);
      vec_t t;
      t.valid = v; t.last = l; t.full = f;
      t.exp_ready = rdy; t.exp_wr = wr; t.exp_gid = gid;
      t.exp_busy = bsy; t.exp_done = dn;
      vecs.push_back(t);
   endfunction

   initial begin
      int n;
      int idle;
      int beats;
      logic [1:0] exp_order [5];

      // Per-cycle vectors: inputs applied after the falling edge, outputs
      // checked before the next rising edge.
      // 3-beat burst from req0, last on beat 3.
      add(4'b0001, 4'b0000, 0, 4'b0000, 0, 0, 0, 0);
      add(4'b0001, 4'b0000, 0, 4'b0001, 1, 0, 1, 0);
      add(4'b0001, 4'b0000, 0, 4'b0001, 1, 0, 1, 0);
      add(4'b0001, 4'b0001, 0, 4'b0001, 1, 0, 1, 0);
      add(4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 1);
      // rr_ptr=1: req3 beats req0; FIFO full holds the burst for two cycles.
      add(4'b1001, 4'b0000, 0, 4'b0000, 0, 0, 0, 0);
      add(4'b1001, 4'b0000, 1, 4'b0000, 0, 3, 1, 0);
      add(4'b1001, 4'b0000, 1, 4'b0000, 0, 3, 1, 0);
      add(4'b1001, 4'b1000, 0, 4'b1000, 1, 3, 1, 0);
      // rr_ptr=0: req1 wins, then goes silent; req2 valid is ignored.
      add(4'b0110, 4'b0000, 0, 4'b0000, 0, 3, 0, 1);
      add(4'b0100, 4'b0000, 0, 4'b0010, 0, 1, 1, 0);
      add(4'b0100, 4'b0000, 0, 4'b0010, 0, 1, 1, 0);
      // A full cycle during the stall holds the stall count.
      add(4'b0100, 4'b0000, 1, 4'b0000, 0, 1, 1, 0);
      for (int i = 0; i < 6; i++) begin
         add(4'b0100, 4'b0000, 0, 4'b0010, 0, 1, 1, 0);
      end
      // Stall timeout ended the burst; next grant is req2 (rr_ptr=2).
      add(4'b0100, 4'b0000, 0, 4'b0000, 0, 1, 0, 1);
      add(4'b0100, 4'b0100, 0, 4'b0100, 1, 2, 1, 0);
      add(4'b0000, 4'b0000, 0, 4'b0000, 0, 2, 0, 1);
      add(4'b0000, 4'b0000, 0, 4'b0000, 0, 2, 0, 0);

      rst_n              = 1'b0;
      bus.req_valid      = 4'b1111;
      bus.req_last       = '0;
      bus.fifo_full      = 1'b0;
      bus.fifo_half_full = 1'b0;
      set_data(0);
      repeat (2) @(negedge clk);
      #1;
      check("reset.busy",       bus.busy,       0);
      check("reset.burst_done", bus.burst_done, 0);
      check("reset.grant_id",   bus.grant_id,   0);
      check("reset.req_ready",  bus.req_ready,  0);
      check("reset.fifo_wr_en", bus.fifo_wr_en, 0);

      apply_reset();
      for (int k = 0; k < vecs.size(); k++) begin
         bus.req_valid = vecs[k].valid;
         bus.req_last  = vecs[k].last;
         bus.fifo_full = vecs[k].full;
         set_data(k);
         #1;
         check($sformatf("v%0d.req_ready", k),  bus.req_ready,  vecs[k].exp_ready);
         check($sformatf("v%0d.fifo_wr_en", k), bus.fifo_wr_en, vecs[k].exp_wr);
         check($sformatf("v%0d.grant_id", k),   bus.grant_id,   vecs[k].exp_gid);
         check($sformatf("v%0d.busy", k),       bus.busy,       vecs[k].exp_busy);
         check($sformatf("v%0d.burst_done", k), bus.burst_done, vecs[k].exp_done);
         if (vecs[k].exp_wr) begin
            check($sformatf("v%0d.wr_data", k), bus.fifo_wr_data, word_of(int'(vecs[k].exp_gid), k));
         end
         @(negedge clk);
      end

      // Round robin with everybody valid and no last: MAX_BURST beats each,
      // one IDLE cycle between bursts.
      exp_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      apply_reset();
      bus.req_valid = 4'b1111;
      set_data(7);
      #1;
      idle = 1;
      for (int b = 0; b < 5; b++) begin
         n = 0;
         while (!bus.busy && n < 50) begin
            step();
            n++;
            if (!bus.busy) idle++;
         end
         if (!bus.busy) begin
            check($sformatf("rr%0d.grant_timeout", b), 1, 0);
            break;
         end
         if (b > 0) check($sformatf("rr%0d.idle_gap", b), idle, 1);
         check($sformatf("rr%0d.grant_id", b), bus.grant_id, exp_order[b]);
         check($sformatf("rr%0d.wr_data", b), bus.fifo_wr_data, word_of(int'(exp_order[b]), 7));
         beats = 0;
         n = 0;
         while (bus.busy && n < 50) begin
            if (bus.fifo_wr_en) beats++;
            step();
            n++;
         end
         check($sformatf("rr%0d.beats", b), beats, 16);
         check($sformatf("rr%0d.burst_done", b), bus.burst_done, 1);
         idle = 1;
      end

      // Reset in the middle of a burst (beat 4 of a longer packet).
      apply_reset();
      bus.req_valid = 4'b0001;
      bus.req_last  = 4'b0001;
      step();
      check("rst.first_wr", bus.fifo_wr_en, 1);
      step();
      check("rst.first_done", bus.burst_done, 1);
      bus.req_valid = 4'b1001;
      bus.req_last  = 4'b0000;
      step();
      check("rst.grant3", bus.grant_id, 3);
      step();
      step();
      step();
      check("rst.beat4_wr", bus.fifo_wr_en, 1);
      rst_n = 1'b0;
      #1;
      check("rst.busy_now",  bus.busy,       0);
      check("rst.ready_now", bus.req_ready,  0);
      check("rst.wr_en_now", bus.fifo_wr_en, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("rst.regrant_id",   bus.grant_id, 0);
      check("rst.regrant_busy", bus.busy,     1);

      // Half-full throttle on new grants only.
      apply_reset();
      bus.fifo_half_full = 1'b1;
      bus.req_valid      = 4'b0010;
      bus.req_last       = 4'b0000;
`ifdef WR_ARB_HALF_FULL_THROTTLE_EN
      for (int i = 0; i < 4; i++) begin
         step();
         check($sformatf("hf.hold%0d", i), bus.busy, 0);
      end
      bus.fifo_half_full = 1'b0;
      step();
`else
      step();
`endif
      check("hf.grant_busy", bus.busy,     1);
      check("hf.grant_id",   bus.grant_id, 1);
      bus.fifo_half_full = 1'b1;
      #1;
      check("hf.midburst_ready", bus.req_ready,  4'b0010);
      check("hf.midburst_wr",    bus.fifo_wr_en, 1);
      bus.req_last = 4'b0010;
      step();
      check("hf.end_done", bus.burst_done, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Write-side arbiter for the team's 256-deep async FIFO, running entirely in the wr_clk domain. Shares the single FIFO write port among NUM_REQ producers using round-robin, burst-granular grants. It honours the FIFO full flag and optionally throttles on half_full. Lock-out of a stalled producer is prevented by a stall timeout.

Parameters:
NUM_REQ, 4, number of requesting producers (>=2)
DATA_WIDTH, 32, word width; matches FIFO DATA_WIDTH
MAX_BURST, 16, max beats per grant (>=1)
STALL_LIMIT, 8, consecutive idle granted cycles before the burst is forcibly ended (>=1)

Ports:
wr_clk  in  1  write-domain clock; the block's only clock
wr_rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester word valid
req_data  in  NUM_REQ*DATA_WIDTH  packed words; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
req_last  in  NUM_REQ  word is last of packet; ends the burst
req_ready  out  NUM_REQ  per-requester accept
fifo_full  in  1  FIFO full flag
fifo_half_full  in  1  FIFO half_full flag
fifo_wr_en  out  1  FIFO write enable
fifo_wr_data  out  DATA_WIDTH  FIFO write data
grant_id  out  $clog2(NUM_REQ)  current or last granted requester
busy  out  1  burst in progress
burst_done  out  1  one-cycle pulse after a burst ends

Behaviour:
- Clock/reset: one clock (wr_clk); reset wr_rst_n, asynchronous, active-low.
- Reset values: state IDLE, grant_id=0, rr_ptr=0, beat_cnt=0, stall_cnt=0, busy=0, burst_done=0, req_ready=0, fifo_wr_en=0.
- Reset mid-burst forces IDLE immediately. The in-flight beat is not written. Priority restarts at requester 0.
- FSM states: IDLE, BURST.
- IDLE:
  - Grant condition: any req_valid and fifo_full=0.
  - Winner: first requester with req_valid set, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - On grant, register grant_id=winner and clear beat_cnt and stall_cnt; enter BURST next cycle (1-cycle arbitration latency).
  - req_ready is all zero in IDLE.
- BURST:
  - req_ready[grant_id] = !fifo_full; all other ready bits are 0.
  - Beat accepted when req_valid[grant_id] && req_ready[grant_id].
  - fifo_wr_en = accept, and fifo_wr_data = req_data of grant_id. Both are combinational, zero latency.
  - fifo_wr_data is don't-care when fifo_wr_en=0, but is driven from grant_id, never X.
- Burst end occurs on the accepting cycle when req_last[grant_id]=1, or when beat_cnt==MAX_BURST-1.
- Stall:
  - A stall cycle is BURST with fifo_full=0 and req_valid[grant_id]=0.
  - stall_cnt increments on each stall cycle and clears on accept.
  - fifo_full cycles hold stall_cnt.
  - stall_cnt==STALL_LIMIT-1 during a stall cycle ends the burst with no write.
- On burst end:
  - Next state IDLE; rr_ptr = (grant_id+1) mod NUM_REQ.
  - burst_done=1 for exactly the following cycle; grant_id holds.
  - No back-to-back grant: at least one IDLE cycle separates bursts.
- busy = (state==BURST), registered.
- Widths: beat_cnt is $clog2(MAX_BURST+1) bits; stall_cnt is $clog2(STALL_LIMIT+1) bits; rr_ptr wraps at NUM_REQ, including non-power-of-2 values.
- fifo_full rising mid-burst: ready drops the same cycle and the burst holds (no stall count). Writing resumes when full clears.
- MAX_BURST=1: every burst is one beat.
- req_valid from non-granted requesters is ignored until IDLE.

Optional Feature:
Macro WR_ARB_HALF_FULL_THROTTLE_EN.
- Defined: the IDLE grant condition additionally requires fifo_half_full=0. An in-progress burst is unaffected.
- Undefined: fifo_half_full is ignored (port retained, unused).

Test Plan:
- Reset, req_valid=4'b0001, req0 sends 3 words, last on word 3, fifo_full=0 -> grant_id=0 one cycle after valid; 3 consecutive fifo_wr_en with matching data; burst_done pulses next cycle; rr_ptr=1.
- All four requesters continuously valid, req_last never set, MAX_BURST=16 -> grants in order 0,1,2,3,0; exactly 16 writes per grant; one IDLE cycle between bursts.
- Granted req2 drops valid after 2 beats, STALL_LIMIT=8 -> burst ends after 8 idle cycles; burst_done=1; next grant goes to req3 if valid.
- fifo_full forced 1 for 5 cycles mid-burst -> req_ready=0 and no fifo_wr_en for those cycles; stall_cnt unchanged; writing resumes with no data loss or duplication.
- With WR_ARB_HALF_FULL_THROTTLE_EN and fifo_half_full=1 in IDLE, req1 valid -> no grant until half_full=0; same stimulus without the macro -> grant after 1 cycle.
- Assert wr_rst_n=0 mid-burst (beat 4 of 10) -> busy, req_ready, fifo_wr_en go 0 immediately; after release the first grant uses the rr_ptr=0 search order.
